// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RISC-V constants and fetch queue entry type
package riscv_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - 2-entry fetch queue with registered head and flush
module fetch_fifo
    import riscv_pkg::*;
(
    input  logic         clk,
    input  logic         resetn,
    input  logic         push_i,
    input  fetch_entry_t push_data_i,
    input  logic         pop_i,
    input  logic         flush_i,
    output logic [1:0]   count_o,
    output fetch_entry_t head_o
);

    fetch_entry_t head_q, head_d;
    fetch_entry_t tail_q, tail_d;
    logic [1:0]   count_q, count_d;

    // Shift organisation: the head is always its own register, so the
    // consumer-facing outputs come straight from flops.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            count_d = 2'd0;
        end else begin
            case ({push_i, pop_i})
                2'b10: begin
                    if (count_q == 2'd0) head_d = push_data_i;
                    else                 tail_d = push_data_i;
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    head_d  = tail_q;
                    count_d = count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        head_d = push_data_i;
                    end else begin
                        head_d = tail_q;
                        tail_d = push_data_i;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign head_o  = head_q;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with 2-entry queue and redirect flush
module fetch_unit
    import riscv_pkg::*;
#(
    parameter int          MEM_WORDS_LOG2 = 8,
    parameter logic [31:0] RESET_PC       = RESET_PC_DEFAULT
) (
    input  logic                      clk,
    input  logic                      resetn,
    output logic [MEM_WORDS_LOG2-1:0] mem_addr,
    output logic                      mem_rstrb,
    input  logic [31:0]               mem_rdata,
    input  logic                      redirect_valid,
    input  logic [31:0]               redirect_pc,
    output logic                      instr_valid,
    output logic [31:0]               instr,
    output logic [31:0]               instr_pc,
    input  logic                      instr_ready
);

    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic [31:0]  req_pc_q;
    logic         inflight_q;
    logic         pop, push;
    logic [1:0]   count;
    logic [2:0]   occupancy;
    fetch_entry_t head, push_data;

    assign instr_valid = (count != 2'd0);
    assign instr       = head.instr;
    assign instr_pc    = head.pc;
    assign pop         = instr_valid && instr_ready;

    // Slots already spoken for once this cycle's pop and returning word settle.
    assign occupancy = {1'b0, count} + {2'b00, inflight_q} - {2'b00, pop};
    assign mem_rstrb = resetn && !redirect_valid && (occupancy < 3'd2);
    assign mem_addr  = fetch_pc_q[MEM_WORDS_LOG2+1:2];

    assign push      = inflight_q && !redirect_valid;
    assign push_data = '{instr: mem_rdata, pc: req_pc_q};

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (redirect_valid)  fetch_pc_d = align_pc(redirect_pc);
        else if (mem_rstrb)  fetch_pc_d = fetch_pc_q + 32'd4;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            fetch_pc_q <= align_pc(RESET_PC);
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            inflight_q <= mem_rstrb;
            if (mem_rstrb) req_pc_q <= fetch_pc_q;
        end
    end

    fetch_fifo u_fifo (
        .clk         (clk),
        .resetn      (resetn),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .flush_i     (redirect_valid),
        .count_o     (count),
        .head_o      (head)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [7:0]  mem_addr;
    logic        mem_rstrb;
    logic [31:0] mem_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready = 1'b0;

    int          checks = 0;
    int          errors = 0;
    int          strobes;
    logic [31:0] mem [256];

    always #5 clk = ~clk;

    fetch_unit #(.MEM_WORDS_LOG2(8), .RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .mem_addr       (mem_addr),
        .mem_rstrb      (mem_rstrb),
        .mem_rdata      (mem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready)
    );

    always @(posedge clk) begin
        if (mem_rstrb) mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic rst_n, input logic rdy, input logic rv, input logic [31:0] rpc);
        @(posedge clk);
        #1;
        resetn         = rst_n;
        instr_ready    = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        #1;
    endtask

    task automatic expect_head(input string tag, input logic [31:0] pc);
        logic [31:0] word;
        word = mem[pc[9:2]];
        chk({tag, " valid"}, 64'(instr_valid), 64'd1);
        chk({tag, " pc"}, 64'(instr_pc), 64'(pc));
        chk({tag, " instr"}, 64'(instr), 64'(word));
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        drive(1'b0, 1'b1, 1'b0, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 | 32'(i);
        mem[0] = 32'h0000_0033;
        mem[1] = 32'h0010_0093;

        // reset state and streaming
        do_reset();
        chk("rst valid", 64'(instr_valid), 64'd0);
        chk("rst instr", 64'(instr), 64'd0);
        chk("rst pc", 64'(instr_pc), 64'd0);
        chk("rst rstrb", 64'(mem_rstrb), 64'd0);
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        chk("t1 c0 rstrb", 64'(mem_rstrb), 64'd1);
        chk("t1 c0 addr", 64'(mem_addr), 64'd0);
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        chk("t1 c1 rstrb", 64'(mem_rstrb), 64'd1);
        chk("t1 c1 addr", 64'(mem_addr), 64'd1);
        chk("t1 c1 valid", 64'(instr_valid), 64'd0);
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b1, 1'b0, 32'h0);
            expect_head($sformatf("t1 c%0d", k + 2), 32'(k * 4));
            chk($sformatf("t1 c%0d rstrb", k + 2), 64'(mem_rstrb), 64'd1);
        end

        // backpressure
        do_reset();
        strobes = 0;
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 1'b0, 1'b0, 32'h0);
            if (mem_rstrb) strobes++;
            if (k >= 2) expect_head($sformatf("t2 stall%0d", k), 32'h0);
        end
        chk("t2 strobes", 64'(strobes), 64'd2);
        chk("t2 full rstrb", 64'(mem_rstrb), 64'd0);
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b1, 1'b0, 32'h0);
            expect_head($sformatf("t2 drain%0d", k), 32'(k * 4));
        end

        // redirect with a full queue
        do_reset();
        for (int k = 0; k < 4; k++) drive(1'b1, 1'b1, 1'b0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        expect_head("t3 pre", 32'h8);
        drive(1'b1, 1'b0, 1'b1, 32'h20);
        expect_head("t3 R", 32'h8);
        chk("t3 R rstrb", 64'(mem_rstrb), 64'd0);
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        chk("t3 R1 valid", 64'(instr_valid), 64'd0);
        chk("t3 R1 rstrb", 64'(mem_rstrb), 64'd1);
        chk("t3 R1 addr", 64'(mem_addr), 64'd8);
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        chk("t3 R2 valid", 64'(instr_valid), 64'd0);
        chk("t3 R2 addr", 64'(mem_addr), 64'd9);
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        expect_head("t3 R3", 32'h20);
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        expect_head("t3 R4", 32'h24);

        // misaligned redirect while streaming
        drive(1'b1, 1'b1, 1'b1, 32'h23);
        chk("t4 R rstrb", 64'(mem_rstrb), 64'd0);
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        chk("t4 R1 valid", 64'(instr_valid), 64'd0);
        chk("t4 R1 addr", 64'(mem_addr), 64'd8);
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        chk("t4 R2 valid", 64'(instr_valid), 64'd0);
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        expect_head("t4 R3", 32'h20);

        // memory index wrap
        drive(1'b1, 1'b1, 1'b1, 32'h3FC);
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        chk("t5 R1 addr", 64'(mem_addr), 64'd255);
        chk("t5 R1 rstrb", 64'(mem_rstrb), 64'd1);
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        chk("t5 R2 addr", 64'(mem_addr), 64'd0);
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        expect_head("t5 R3", 32'h3FC);
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        expect_head("t5 R4", 32'h400);

        // reset pulse with queued and in-flight data
        do_reset();
        for (int k = 0; k < 4; k++) drive(1'b1, 1'b1, 1'b0, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        chk("t6 rst rstrb", 64'(mem_rstrb), 64'd0);
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        chk("t6 c0 valid", 64'(instr_valid), 64'd0);
        chk("t6 c0 instr", 64'(instr), 64'd0);
        chk("t6 c0 pc", 64'(instr_pc), 64'd0);
        chk("t6 c0 rstrb", 64'(mem_rstrb), 64'd1);
        chk("t6 c0 addr", 64'(mem_addr), 64'd0);
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        chk("t6 c1 valid", 64'(instr_valid), 64'd0);
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        expect_head("t6 c2", 32'h0);
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        expect_head("t6 c3", 32'h4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
